// File: rtl/rib_uart_loader.sv
// rib_uart_loader: 8N1 UART image loader acting as rib master 2; define RIB_UART_LOADER_CSUM_EN to expect a trailing XOR checksum byte.
// Latency: each word is written one cycle after its 4th byte; no backpressure, the rib always grants master 2 in that cycle.
module rib_uart_loader #(
  parameter int          CLK_DIV   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 4096,
  parameter int          CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [31:0] m_wraddr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int            TW     = $clog2(CLK_DIV) + 1;
  localparam logic [TW-1:0] T_HALF = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLK_DIV - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef RIB_UART_LOADER_CSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd5;
`endif

  logic          rx_s1, rx_s2, rx_prev;
  logic [1:0]    rx_state;
  logic [TW-1:0] rx_tmr;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_dat;
  logic          rx_vld;
  logic          frame_err;

  logic [2:0]       state;
  logic [1:0]       byte_idx;
  logic [31:0]      len;
  logic [31:0]      word;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      len_full;
  logic             last_word;
  logic             unused_rdata;
`ifdef RIB_UART_LOADER_CSUM_EN
  logic [7:0]       csum;
`endif

  assign unused_rdata = ^m_rdata;

  // Sync flops preset high so reset release never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_tmr    <= '0;
      rx_bit    <= '0;
      rx_dat    <= '0;
      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= uart_rx;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      rx_vld    <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_tmr   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_tmr == T_HALF) begin
            rx_tmr   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_tmr <= rx_tmr + TW'(1);
          end
        end
        RX_DATA: begin
          if (rx_tmr == T_FULL) begin
            rx_tmr <= '0;
            rx_dat <= {rx_s2, rx_dat[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_tmr <= rx_tmr + TW'(1);
          end
        end
        default: begin
          if (rx_tmr == T_FULL) begin
            rx_tmr    <= '0;
            rx_vld    <= rx_s2;
            frame_err <= !rx_s2;
            rx_state  <= RX_IDLE;
          end else begin
            rx_tmr <= rx_tmr + TW'(1);
          end
        end
      endcase
    end
  end

  assign len_full  = {rx_dat, len[23:0]};
  assign last_word = (32'(cnt) + 32'd1) == len;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      byte_idx <= '0;
      len      <= '0;
      word     <= '0;
      cnt      <= '0;
      load_err <= 1'b0;
`ifdef RIB_UART_LOADER_CSUM_EN
      csum     <= '0;
`endif
    end else if (frame_err && state != S_IDLE) begin
      // Already-written words stay in memory; only the partial word is lost.
      state    <= S_IDLE;
      load_err <= 1'b1;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_vld && rx_dat == 8'h55) begin
            state    <= S_LEN;
            load_err <= 1'b0;
            byte_idx <= '0;
            cnt      <= '0;
`ifdef RIB_UART_LOADER_CSUM_EN
            csum     <= '0;
`endif
          end
        end
        S_LEN: begin
          if (rx_vld) begin
            len[{byte_idx, 3'b000} +: 8] <= rx_dat;
            byte_idx <= byte_idx + 2'd1;
`ifdef RIB_UART_LOADER_CSUM_EN
            csum     <= csum ^ rx_dat;
`endif
            if (byte_idx == 2'd3) begin
              if (len_full == 32'd0) begin
                state <= S_DONE;
              end else if (len_full > 32'(MAX_WORDS)) begin
                load_err <= 1'b1;
                state    <= S_IDLE;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (rx_vld) begin
            word     <= {rx_dat, word[31:8]};
            byte_idx <= byte_idx + 2'd1;
`ifdef RIB_UART_LOADER_CSUM_EN
            csum     <= csum ^ rx_dat;
`endif
            if (byte_idx == 2'd3) state <= S_WRITE;
          end
        end
        S_WRITE: begin
          cnt <= cnt + CNT_W'(1);
          if (last_word) begin
`ifdef RIB_UART_LOADER_CSUM_EN
            state <= S_CSUM;
`else
            state <= S_DONE;
`endif
          end else begin
            state <= S_DATA;
          end
        end
`ifdef RIB_UART_LOADER_CSUM_EN
        S_CSUM: begin
          if (rx_vld) begin
            if (rx_dat == csum) begin
              state <= S_DONE;
            end else begin
              load_err <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end
`endif
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m_req     = (state == S_WRITE);
  assign m_we      = (state == S_WRITE);
  assign m_wraddr  = m_req ? (BASE_ADDR + (32'(cnt) << 2)) : 32'd0;
  assign m_wdata   = m_req ? word : 32'd0;
  assign load_done = (state == S_DONE);
`ifdef RIB_UART_LOADER_CSUM_EN
  assign cpu_hold  = (state == S_LEN) || (state == S_DATA) || (state == S_WRITE) || (state == S_CSUM);
`else
  assign cpu_hold  = (state == S_LEN) || (state == S_DATA) || (state == S_WRITE);
`endif

endmodule

// File: tb/tb_rib_uart_loader.sv
// Directed bench for rib_uart_loader: table of framed images plus hand sequences for glitch, framing error and reset abort.
`timescale 1ns/1ps
module tb_rib_uart_loader;

  localparam int CLK_DIV = 16;
`ifdef RIB_UART_LOADER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uart_rx = 1'b1;
  logic [31:0] m_wraddr, m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic        m_req, m_we, cpu_hold, load_done, load_err;

  always #5 clk = ~clk;

  rib_uart_loader #(
    .CLK_DIV(CLK_DIV), .BASE_ADDR(32'h0000_0000), .MAX_WORDS(4096), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .m_wraddr(m_wraddr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_req(m_req), .m_we(m_we), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          rxv_cnt = 0;
  int          bad_req = 0;
  logic        prev_req = 1'b0;
  logic [31:0] wr_a [64];
  logic [31:0] wr_d [64];

  // Write log: every m_req cycle must be a single-cycle write.
  always @(negedge clk) begin
    if (m_req) begin
      wr_a[wr_cnt % 64] = m_wraddr;
      wr_d[wr_cnt % 64] = m_wdata;
      wr_cnt++;
      if (!m_we || prev_req) bad_req++;
    end
    prev_req = m_req;
    if (load_done) done_cnt++;
    if (dut.rx_vld) rxv_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CLK_DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  typedef struct packed {
    logic [0:15][7:0] b;
    logic [4:0]       nb;
    logic             cs;
    logic [1:0]       n_wr;
    logic [31:0]      a0, d0, a1, d1;
    logic [1:0]       n_done;
    logic             err;
  } vec_t;

  localparam int NV = 4;
  vec_t vecs [NV];

  initial begin
    int wb;
    int db;
    int rb;

    // b holds the frames in order; when cs is set the checksum byte follows the nb image bytes.
    vecs[0] = '{b: {8'h55, 8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                    8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28, 16'h0},
                nb: 5'd13, cs: 1'b1, n_wr: 2'd2,
                a0: 32'h0, d0: 32'h1234_5678, a1: 32'h4, d1: 32'hDEAD_BEEF,
                n_done: 2'd1, err: 1'b0};
    vecs[1] = '{b: {8'hAA, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 72'h0},
                nb: 5'd7, cs: 1'b0, n_wr: 2'd0,
                a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0,
                n_done: 2'd1, err: 1'b0};
    vecs[2] = '{b: {8'h55, 8'h01, 8'h10, 8'h00, 8'h00, 88'h0},
                nb: 5'd5, cs: 1'b0, n_wr: 2'd0,
                a0: 32'h0, d0: 32'h0, a1: 32'h0, d1: 32'h0,
                n_done: 2'd0, err: 1'b1};
    vecs[3] = '{b: {8'h11, 8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'h55, 8'hAA, 8'h55, 8'hAA,
                    8'h01, 40'h0},
                nb: 5'd10, cs: 1'b1, n_wr: 2'd1,
                a0: 32'h0, d0: 32'hAA55_AA55, a1: 32'h0, d1: 32'h0,
                n_done: 2'd1, err: 1'b0};

    do_reset;
    chk("reset m_req", m_req, 0);
    chk("reset m_we", m_we, 0);
    chk("reset m_wraddr", m_wraddr, 0);
    chk("reset m_wdata", m_wdata, 0);
    chk("reset cpu_hold", cpu_hold, 0);
    chk("reset load_done", load_done, 0);
    chk("reset load_err", load_err, 0);

    for (int i = 0; i < NV; i++) begin
      int n;
      do_reset;
      wb = wr_cnt;
      db = done_cnt;
      n = int'(vecs[i].nb) + ((vecs[i].cs && CSUM_ON) ? 1 : 0);
      for (int j = 0; j < n; j++) send_frame(vecs[i].b[j], 1'b1);
      repeat (8) @(negedge clk);
      chk($sformatf("v%0d writes", i), wr_cnt - wb, 32'(vecs[i].n_wr));
      if (vecs[i].n_wr > 0) begin
        chk($sformatf("v%0d addr0", i), wr_a[wb % 64], vecs[i].a0);
        chk($sformatf("v%0d data0", i), wr_d[wb % 64], vecs[i].d0);
      end
      if (vecs[i].n_wr > 1) begin
        chk($sformatf("v%0d addr1", i), wr_a[(wb + 1) % 64], vecs[i].a1);
        chk($sformatf("v%0d data1", i), wr_d[(wb + 1) % 64], vecs[i].d1);
      end
      chk($sformatf("v%0d load_done", i), done_cnt - db, 32'(vecs[i].n_done));
      chk($sformatf("v%0d load_err", i), load_err, vecs[i].err);
      chk($sformatf("v%0d cpu_hold", i), cpu_hold, 0);
    end

    // Glitch shorter than half a bit is rejected, and the receiver still works afterwards.
    do_reset;
    rb = rxv_cnt;
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk);
    chk("glitch rx_valid", rxv_cnt - rb, 0);
    chk("glitch cpu_hold", cpu_hold, 0);
    chk("glitch load_err", load_err, 0);
    send_frame(8'h55, 1'b1);
    chk("post-glitch sync", cpu_hold, 1);

    // Length exactly MAX_WORDS is accepted.
    do_reset;
    send_frame(8'h55, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h10, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    chk("max len hold", cpu_hold, 1);
    chk("max len err", load_err, 0);

    // Framing error mid-word, then a fresh 0x55 clears the sticky error.
    do_reset;
    wb = wr_cnt;
    send_frame(8'h55, 1'b1);
    send_frame(8'h01, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    chk("ferr hold before", cpu_hold, 1);
    send_frame(8'h33, 1'b0);
    chk("ferr load_err", load_err, 1);
    chk("ferr cpu_hold", cpu_hold, 0);
    chk("ferr writes", wr_cnt - wb, 0);
    send_frame(8'h55, 1'b1);
    chk("resync clears err", load_err, 0);
    chk("resync hold", cpu_hold, 1);

    // Reset during the second word of a three-word load.
    do_reset;
    wb = wr_cnt;
    send_frame(8'h55, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h04, 1'b1);
    send_frame(8'h05, 1'b1);
    send_frame(8'h06, 1'b1);
    chk("mid-load hold", cpu_hold, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort cpu_hold", cpu_hold, 0);
    chk("abort m_req", m_req, 0);
    chk("abort m_we", m_we, 0);
    chk("abort m_wraddr", m_wraddr, 0);
    chk("abort m_wdata", m_wdata, 0);
    chk("abort load_done", load_done, 0);
    chk("abort load_err", load_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send_frame(8'h07, 1'b1);
    send_frame(8'h08, 1'b1);
    repeat (8) @(negedge clk);
    chk("abort writes", wr_cnt - wb, 1);
    chk("abort addr0", wr_a[wb % 64], 32'h0);
    chk("abort data0", wr_d[wb % 64], 32'h0403_0201);

`ifdef RIB_UART_LOADER_CSUM_EN
    // Correct checksum would be 8'h01.
    do_reset;
    wb = wr_cnt;
    db = done_cnt;
    send_frame(8'h55, 1'b1);
    send_frame(8'h01, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hAA, 1'b1);
    send_frame(8'hBB, 1'b1);
    send_frame(8'hCC, 1'b1);
    send_frame(8'hDD, 1'b1);
    send_frame(8'h02, 1'b1);
    repeat (8) @(negedge clk);
    chk("csum writes", wr_cnt - wb, 1);
    chk("csum data0", wr_d[wb % 64], 32'hDDCC_BBAA);
    chk("csum load_done", done_cnt - db, 0);
    chk("csum load_err", load_err, 1);
    chk("csum cpu_hold", cpu_hold, 0);
`endif

    chk("write pulse shape", bad_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
